// File: rtl/led_fader_if.sv
// Control and status bundle for the LED fader.
// The master side drives mode, enable and level writes; the slave side
// (the fader itself) returns pin drive, levels, chase channel and step pulse.
interface led_fader_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      i_enable;
  logic [1:0]                i_mode;
  logic                      i_wr;
  logic [CH_W-1:0]           i_wr_ch;
  logic [WIDTH-1:0]          i_wr_value;
  logic [CHANNELS-1:0]       o_led;
  logic [CHANNELS*WIDTH-1:0] o_level;
  logic [CH_W-1:0]           o_active_ch;
  logic                      o_step;

  modport master (
    output i_enable, i_mode, i_wr, i_wr_ch, i_wr_value,
    input  o_led, o_level, o_active_ch, o_step
  );

  modport slave (
    input  i_enable, i_mode, i_wr, i_wr_ch, i_wr_value,
    output o_led, o_level, o_active_ch, o_step
  );
endinterface

// File: rtl/led_fader.sv
// Multi-channel LED PWM engine with a brightness sequencer.
//
// Sequencer direction state (dir_q):
//   state    | meaning
//   DIR_UP   | ramp level rises toward PEAK, turns at PEAK
//   DIR_DOWN | ramp level falls toward 0, turns at 0 (CHASE moves on to next channel)
//
// Mode (mode_q, registered copy of i_mode):
//   MANUAL | levels only change through writes
//   CHASE  | one channel breathes at a time, others held at 0
//   UNISON | all channels breathe together
//   BLINK  | all channels toggle 0 <-> PEAK each step
module led_fader #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PEAK     = 32,
  parameter int PRESCALE = 256,
  parameter int INVERT   = 1
) (
  input logic       i_clk,
  input logic       i_reset_n,
  led_fader_if.slave bus
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [WIDTH-1:0] PEAK_LVL = WIDTH'(PEAK);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic             INV      = (INVERT != 0);

  if (CHANNELS < 1 || WIDTH < 2 || WIDTH > 16 || PRESCALE < 2 ||
      PEAK < 1 || PEAK > (2**WIDTH) - 1) begin : g_bad_params
    $error("led_fader: parameter out of range (PEAK must be 1..2^WIDTH-1)");
  end

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_UNISON = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  mode_t               mode_q;
  dir_t                dir_q;
  logic [CH_W-1:0]     active_ch_q;
  logic [WIDTH-1:0]    level_q [CHANNELS];
  logic [WIDTH-1:0]    pwm_cnt;
  logic [PS_W-1:0]     presc_cnt;
  logic                step_q;
  logic [CHANNELS-1:0] led_q;

  logic             mode_change;
  logic             tick;
  logic             wr_ok;
  logic [CH_W-1:0]  next_ch;
  logic [WIDTH-1:0] ramp_ref;
  logic [WIDTH-1:0] ramp_lvl;
  dir_t             ramp_dir;
  logic             ramp_bottom;

  // A mode switch takes priority: the step tick and any write in that cycle are lost.
  assign mode_change = (bus.i_mode != mode_q);
  assign tick        = bus.i_enable && (presc_cnt == PS_LAST) && !mode_change;
  assign wr_ok       = bus.i_wr && (32'(bus.i_wr_ch) < 32'(CHANNELS));
  assign next_ch     = (active_ch_q == CH_LAST) ? '0 : active_ch_q + 1'b1;

  // Shared breathing ramp: next level/direction from the reference channel.
  always_comb begin
    ramp_ref    = (mode_q == MODE_CHASE) ? level_q[active_ch_q] : level_q[0];
    ramp_lvl    = ramp_ref;
    ramp_dir    = dir_q;
    ramp_bottom = 1'b0;
    if (dir_q == DIR_UP) begin
      if (ramp_ref < PEAK_LVL) begin
        ramp_lvl = ramp_ref + 1'b1;
      end else begin
        ramp_dir = DIR_DOWN;
        ramp_lvl = ramp_ref - 1'b1;
      end
    end else begin
      if (ramp_ref != '0) begin
        ramp_lvl = ramp_ref - 1'b1;
      end else begin
        ramp_dir    = DIR_UP;
        ramp_lvl    = WIDTH'(1);
        ramp_bottom = 1'b1;
      end
    end
  end

  // Free-running PWM counter and enable-gated step prescaler.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt   <= '0;
      presc_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (mode_change) begin
        presc_cnt <= '0;
      end else if (bus.i_enable) begin
        presc_cnt <= (presc_cnt == PS_LAST) ? '0 : presc_cnt + 1'b1;
      end
    end
  end

  // Sequencer: mode tracking, ramp direction, chase channel and levels.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_q      <= MODE_MANUAL;
      dir_q       <= DIR_UP;
      active_ch_q <= '0;
      step_q      <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) level_q[n] <= '0;
    end else begin
      step_q <= tick;
      if (mode_change) begin
        mode_q      <= mode_t'(bus.i_mode);
        dir_q       <= DIR_UP;
        active_ch_q <= '0;
        for (int n = 0; n < CHANNELS; n++) level_q[n] <= '0;
      end else begin
        case (mode_q)
          MODE_MANUAL: begin
            if (wr_ok) level_q[bus.i_wr_ch] <= bus.i_wr_value;
          end
          MODE_CHASE: begin
            if (tick) begin
              dir_q <= ramp_dir;
              if (ramp_bottom) begin
                // Old channel is already at 0; hand the ramp to the next one.
                active_ch_q      <= next_ch;
                level_q[next_ch] <= ramp_lvl;
              end else begin
                level_q[active_ch_q] <= ramp_lvl;
              end
            end
          end
          MODE_UNISON: begin
            if (tick) begin
              dir_q <= ramp_dir;
              for (int n = 0; n < CHANNELS; n++) level_q[n] <= ramp_lvl;
            end
          end
          MODE_BLINK: begin
            if (tick) begin
              for (int n = 0; n < CHANNELS; n++)
                level_q[n] <= (level_q[0] == '0) ? PEAK_LVL : '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered pin drive; reset leaves every LED dark.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      led_q <= {CHANNELS{INV}};
    end else begin
      for (int n = 0; n < CHANNELS; n++) led_q[n] <= (level_q[n] > pwm_cnt) ^ INV;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_pack
    assign bus.o_level[n*WIDTH +: WIDTH] = level_q[n];
  end

  assign bus.o_led       = led_q;
  assign bus.o_active_ch = active_ch_q;
  assign bus.o_step      = step_q;

endmodule
